demux_lane_router: RTL and testbench

//   Registered 1-to-LANES demultiplexer. It is the receive-side counterpart of the mux2/mux3 lane-select trees.
//   A single DATA_W-bit input stream is steered into one of LANES holding registers.

---
 rtl/demux_lane_router.sv | 91 +++++++++
 tb/tb_demux_lane_router.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_lane_router.sv
// demux_lane_router
//   Registered 1-to-LANES demultiplexer. One DATA_W-bit input stream is
//   steered into one of LANES holding registers. Each register has its own
//   valid/ack handshake toward its consumer. The target lane is either the
//   explicit select (manual mode) or an internal round-robin pointer (auto
//   mode). Auto mode re-expands a time-multiplexed stream into parallel lanes.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   din         input data word
//   din_valid   din holds a word to deliver
//   din_ready   target lane is empty; word is taken this cycle if din_valid
//   sel         target lane in manual mode
//   auto_en     1 = target is ptr, 0 = target is sel
//   lane_data   lane i at bits [i*DATA_W +: DATA_W]
//   lane_valid  lane i holds an unconsumed word
//   lane_ack    consumer of lane i takes the word
//   ptr         current round-robin pointer
//   frame_done  one-cycle pulse after an auto-mode accept into lane LANES-1
//   ovf_cnt     saturating count of stalled cycles (din_valid & ~din_ready)
//
// Handshake
//   Input side: a word transfers on a clock edge where din_valid and
//   din_ready are both 1. din_ready depends only on the target lane's
//   registered valid bit (plus rst), never on din_valid.
//   Lane side: a word is consumed on a clock edge where lane_valid[i] and
//   lane_ack[i] are both 1; lane_ack to an empty lane has no effect.
//   There is no bypass: a lane freed by an ack becomes ready one cycle later.

module demux_lane_router #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto_en,
  output logic [DATA_W*LANES-1:0]   lane_data,
  output logic [LANES-1:0]          lane_valid,
  input  logic [LANES-1:0]          lane_ack,
  output logic [SEL_W-1:0]          ptr,
  output logic                      frame_done,
  output logic [7:0]                ovf_cnt
);

  logic [SEL_W-1:0] tgt;
  logic             accept;

  assign tgt       = auto_en ? ptr : sel;
  // rst gates ready so no word is taken during a reset cycle.
  assign din_ready = ~lane_valid[tgt] & ~rst;
  assign accept    = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_data  <= '0;
      lane_valid <= '0;
      ptr        <= '0;
      frame_done <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        // Accept and ack can never hit the same lane in one cycle: accept
        // requires the lane to be empty, and an ack to an empty lane is a no-op.
        if (accept && (tgt == SEL_W'(i))) begin
          lane_data[i*DATA_W +: DATA_W] <= din;
          lane_valid[i]                 <= 1'b1;
        end else if (lane_ack[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end

      // LANES is a power of two, so natural overflow gives the wrap to 0.
      if (accept && auto_en) begin
        ptr <= ptr + SEL_W'(1);
      end

      frame_done <= accept & auto_en & (ptr == SEL_W'(LANES - 1));

      if (din_valid && !din_ready && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_router.sv
module tb_demux_lane_router;

  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    rst;
  logic [DATA_W-1:0]       din;
  logic                    din_valid;
  logic                    din_ready;
  logic [SEL_W-1:0]        sel;
  logic                    auto_en;
  logic [DATA_W*LANES-1:0] lane_data;
  logic [LANES-1:0]        lane_valid;
  logic [LANES-1:0]        lane_ack;
  logic [SEL_W-1:0]        ptr;
  logic                    frame_done;
  logic [7:0]              ovf_cnt;

  demux_lane_router #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sel        (sel),
    .auto_en    (auto_en),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .lane_ack   (lane_ack),
    .ptr        (ptr),
    .frame_done (frame_done),
    .ovf_cnt    (ovf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected {lane, data} in acceptance order
  logic [SEL_W+DATA_W-1:0] exp_q[$];
  int n_vec;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic a, input logic [SEL_W-1:0] s,
                      input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] lane);
    auto_en   = a;
    sel       = s;
    din       = d;
    din_valid = 1'b1;
    exp_q.push_back({lane, d});
    step();
    din_valid = 1'b0;
  endtask

  task automatic ack(input logic [LANES-1:0] m);
    lane_ack = m;
    step();
    lane_ack = '0;
  endtask

  logic [DATA_W-1:0] pat [8];
  int fd_cnt;

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    sel = '0;
    auto_en = 1'b0;
    lane_ack = '0;

    // monitor: a rising lane_valid bit means a newly delivered word
    fork
      begin
        logic [LANES-1:0] prev;
        logic [SEL_W+DATA_W-1:0] e;
        prev = '0;
        forever begin
          @(negedge clk);
          for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i] && !prev[i]) begin
              if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: lane %0d data %0h, nothing expected", i,
                         lane_data[i*DATA_W +: DATA_W]);
              end else begin
                e = exp_q.pop_front();
                chk("lane_word", {53'd0, SEL_W'(i), lane_data[i*DATA_W +: DATA_W]}, {53'd0, e});
              end
            end
          end
          prev = lane_valid;
        end
      end
    join_none

    // reset state
    step();
    step();
    chk("rst_lane_valid", 64'(lane_valid), 64'h0);
    chk("rst_lane_data", lane_data, 64'h0);
    chk("rst_ptr", 64'(ptr), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'h0);
    chk("rst_din_ready", 64'(din_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(din_ready), 64'h1);

    // 1. manual single word
    push(1'b0, 3'd0, 8'ha5, 3'd0);
    chk("t1_lane_valid", 64'(lane_valid), 64'h01);
    chk("t1_lane0", 64'(lane_data[7:0]), 64'ha5);
    chk("t1_ptr", 64'(ptr), 64'h0);
    ack(8'h01);
    chk("t1_acked", 64'(lane_valid), 64'h0);

    // 2. auto fill of all lanes
    pat[0] = 8'ha5; pat[1] = 8'hb8; pat[2] = 8'hc7; pat[3] = 8'hd2;
    pat[4] = 8'ha5; pat[5] = 8'hb8; pat[6] = 8'hc7; pat[7] = 8'hd2;
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      push(1'b1, 3'd0, pat[k], 3'(k));
      fd_cnt += int'(frame_done);
    end
    chk("t2_frame_done_hi", 64'(frame_done), 64'h1);
    chk("t2_lane_valid", 64'(lane_valid), 64'hff);
    chk("t2_lane_data", lane_data, 64'hd2c7b8a5d2c7b8a5);
    chk("t2_ptr_wrap", 64'(ptr), 64'h0);
    step();
    fd_cnt += int'(frame_done);
    chk("t2_frame_done_lo", 64'(frame_done), 64'h0);
    chk("t2_frame_pulses", 64'(fd_cnt), 64'h1);
    ack(8'hff);
    chk("t2_all_acked", 64'(lane_valid), 64'h0);

    // 3. stall on a full lane
    push(1'b0, 3'd2, 8'h3c, 3'd2);
    sel = 3'd2;
    din = 8'h77;
    din_valid = 1'b1;
    #1;
    chk("t3_ready_lo", 64'(din_ready), 64'h0);
    step();
    step();
    step();
    din_valid = 1'b0;
    chk("t3_ovf3", 64'(ovf_cnt), 64'h3);
    chk("t3_lane2_kept", 64'(lane_data[23:16]), 64'h3c);
    lane_ack = 8'h04;
    din_valid = 1'b1;
    #1;
    chk("t3_ready_during_ack", 64'(din_ready), 64'h0);
    step();
    lane_ack = '0;
    #1;
    chk("t3_lane2_freed", 64'(lane_valid[2]), 64'h0);
    chk("t3_ready_after_ack", 64'(din_ready), 64'h1);
    exp_q.push_back({3'd2, 8'h77});
    step();
    din_valid = 1'b0;
    chk("t3_lane2_refill", 64'(lane_valid[2]), 64'h1);
    chk("t3_lane2_data", 64'(lane_data[23:16]), 64'h77);
    chk("t3_ovf4", 64'(ovf_cnt), 64'h4);
    ack(8'h04);

    // 4. ack one lane while accepting into another
    push(1'b0, 3'd1, 8'h11, 3'd1);
    lane_ack = 8'h02;
    push(1'b0, 3'd3, 8'h33, 3'd3);
    lane_ack = '0;
    chk("t4_concurrent", 64'(lane_valid), 64'h08);
    ack(8'h20);
    chk("t4_ack_empty_valid", 64'(lane_valid), 64'h08);
    chk("t4_ack_empty_data", 64'(lane_data[47:40]), 64'hb8);
    ack(8'h08);

    // 5. reset mid-run
    for (int k = 0; k < 5; k++) push(1'b1, 3'd0, 8'(8'he0 + k), 3'(k));
    chk("t5_ptr5", 64'(ptr), 64'h5);
    chk("t5_valid", 64'(lane_valid), 64'h1f);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", 64'(lane_valid), 64'h0);
    chk("t5_rst_data", lane_data, 64'h0);
    chk("t5_rst_ptr", 64'(ptr), 64'h0);
    chk("t5_rst_ovf", 64'(ovf_cnt), 64'h0);
    push(1'b1, 3'd0, 8'h5a, 3'd0);
    chk("t5_lane0", 64'(lane_valid), 64'h01);
    chk("t5_ptr1", 64'(ptr), 64'h1);

    // 6. saturation, then mode switching
    auto_en = 1'b0;
    sel = 3'd0;
    din = 8'hee;
    din_valid = 1'b1;
    for (int k = 0; k < 300; k++) step();
    chk("t6_sat", 64'(ovf_cnt), 64'hff);
    for (int k = 0; k < 5; k++) step();
    din_valid = 1'b0;
    chk("t6_sat_hold", 64'(ovf_cnt), 64'hff);
    chk("t6_lane0_kept", 64'(lane_data[7:0]), 64'h5a);
    ack(8'h01);
    for (int k = 1; k < 4; k++) push(1'b1, 3'd0, 8'(8'h40 + k), 3'(k));
    chk("t6_ptr4", 64'(ptr), 64'h4);
    auto_en = 1'b0;
    step();
    chk("t6_ptr_manual", 64'(ptr), 64'h4);
    push(1'b0, 3'd6, 8'h66, 3'd6);
    chk("t6_ptr_after_manual", 64'(ptr), 64'h4);
    chk("t6_no_frame", 64'(frame_done), 64'h0);
    auto_en = 1'b1;
    step();
    chk("t6_ptr_back_auto", 64'(ptr), 64'h4);
    push(1'b1, 3'd0, 8'h44, 3'd4);
    chk("t6_ptr5", 64'(ptr), 64'h5);

    // final report
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
